// File: rtl/button_conditioner_pkg.sv
// Purpose: shared constants and a width helper for the button conditioner.
// Latency: not applicable (constants and a constant function only).
// Backpressure: not applicable.
package button_conditioner_pkg;

    // Board clock; sample-tick period is chosen for a 5 kHz debounce sample rate.
    localparam int unsigned CLK_FREQ               = 125_000_000;
    localparam int unsigned DEFAULT_WIDTH          = 4;
    localparam int unsigned DEFAULT_SAMPLE_CNT_MAX = CLK_FREQ / 5000;
    localparam int unsigned DEFAULT_PULSE_CNT_MAX  = 150;

    // Counter width needed to hold 0 .. n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Purpose: bundles the raw inputs and the conditioned level/edge outputs.
// Latency: not applicable (wires only).
// Backpressure: none; outputs are levels and single-cycle pulses.
interface button_conditioner_if
    import button_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_out;
    logic [WIDTH-1:0] fall_out;

    // Stimulus side: drives raw buttons, observes conditioned outputs.
    modport master (
        output async_in,
        input  level_out,
        input  rise_out,
        input  fall_out
    );

    // Conditioner side.
    modport slave (
        input  async_in,
        output level_out,
        output rise_out,
        output fall_out
    );
endinterface

// File: rtl/button_conditioner_synchronizer.sv
// Purpose: 2-flop metastability synchronizer for WIDTH independent bits.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module synchronizer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // These flops are deliberately outside the reset domain: they only carry
    // raw pin values, and their power-up value is the all-zero device state.
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    // Next state of the two-stage shift chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Shift chain registers, no reset.
    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        sync_q <= sync_d;
    end

    assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Purpose: synchronize, debounce (saturating per-channel counters) and edge-detect WIDTH buttons.
// Latency: 2 sync + up to SAMPLE_CNT_MAX-1 + (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX + 1 cycles to press; release on first zero tick.
// Backpressure: none; pulses are single-cycle and must be consumed when they occur.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
    parameter int unsigned PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);
    localparam int unsigned   SW        = cnt_width(SAMPLE_CNT_MAX);
    localparam int unsigned   CW        = cnt_width(PULSE_CNT_MAX + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(PULSE_CNT_MAX);

    logic [WIDTH-1:0] sync_in;
    logic [SW-1:0]    samp_cnt_q;
    logic [SW-1:0]    samp_cnt_d;
    logic             tick;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    // Previous-cycle copy of level_q, used only for edge detection.
    logic [WIDTH-1:0] lvl_prev_q;
    logic [WIDTH-1:0] lvl_prev_d;

    synchronizer #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .d   (bus.async_in),
        .q   (sync_in)
    );

    // Shared sample tick: fires on the last count of each sample period.
    always_comb begin
        tick       = (samp_cnt_q == SAMP_LAST);
        samp_cnt_d = tick ? '0 : samp_cnt_q + SW'(1);
    end

    // Sample-period counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_q <= '0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // On a tick: a low sample restarts the count, a high sample counts up
        // and sticks at saturation. Between ticks the count holds.
        always_comb begin
            cnt_d = cnt_q;
            if (tick) begin
                if (!sync_in[i]) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // Per-channel debounce counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Level looks at the next count so it moves in the same cycle as cnt_q.
        assign level_d[i] = (cnt_d == CNT_SAT);
    end

    // Previous level feeds the edge detector.
    always_comb begin
        lvl_prev_d = level_q;
    end

    // Debounced level and its one-cycle-delayed copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= '0;
            lvl_prev_q <= '0;
        end else begin
            level_q    <= level_d;
            lvl_prev_q <= lvl_prev_d;
        end
    end

    assign bus.level_out = level_q;
    assign bus.rise_out  = level_q & ~lvl_prev_q;
    assign bus.fall_out  = ~level_q & lvl_prev_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose: randomized and directed self-checking bench for button_conditioner.
// Latency: reference model predicts outputs every cycle, checked 1 time unit after each rising edge.
// Backpressure: none.
module tb_button_conditioner;
    localparam int W   = 4;
    localparam int SCM = 4;
    localparam int PCM = 3;

    logic clk;
    logic rst_n;

    button_conditioner_if #(.WIDTH(W)) bif();

    button_conditioner #(
        .WIDTH          (W),
        .SAMPLE_CNT_MAX (SCM),
        .PULSE_CNT_MAX  (PCM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw inputs reach the debouncer two edges late; every
    // SCM-th edge after reset is a sample; a channel is pressed once its
    // current run of consecutive high samples reaches PCM.
    logic [W-1:0] dly[$];
    int           m_phase;
    int           run[W];
    logic [W-1:0] m_lvl;
    logic [W-1:0] m_prev;
    int           since_rst;

    // Observed-output statistics for directed checks.
    int n_rise[W];
    int n_fall[W];
    int n_rise1001;
    int n_lvl2;

    task automatic clr_stats();
        for (int c = 0; c < W; c++) begin
            n_rise[c] = 0;
            n_fall[c] = 0;
        end
        n_rise1001 = 0;
        n_lvl2     = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] a, input logic r);
        logic [W-1:0] smp;
        smp = dly.pop_front();
        dly.push_back(a);
        if (!r) begin
            m_phase   = 0;
            since_rst = 0;
            m_lvl     = '0;
            m_prev    = '0;
            for (int c = 0; c < W; c++) run[c] = 0;
        end else begin
            since_rst++;
            m_prev = m_lvl;
            if (m_phase == SCM - 1) begin
                for (int c = 0; c < W; c++) begin
                    run[c]   = smp[c] ? run[c] + 1 : 0;
                    m_lvl[c] = (run[c] >= PCM);
                end
            end
            m_phase = (m_phase + 1) % SCM;
        end
    endtask

    // One clock: drive, let the edge happen, update model, compare, return at negedge.
    task automatic cyc(input logic [W-1:0] a, input logic r);
        bif.async_in = a;
        rst_n        = r;
        @(posedge clk);
        model_edge(a, r);
        #1;
        chk("level", 32'(bif.level_out), 32'(m_lvl));
        chk("rise",  32'(bif.rise_out),  32'(m_lvl & ~m_prev));
        chk("fall",  32'(bif.fall_out),  32'(~m_lvl & m_prev));
        for (int c = 0; c < W; c++) begin
            if (bif.rise_out[c]) n_rise[c]++;
            if (bif.fall_out[c]) n_fall[c]++;
        end
        if (bif.rise_out == 4'b1001) n_rise1001++;
        if (bif.level_out[2])        n_lvl2++;
        @(negedge clk);
    endtask

    logic [W-1:0] a;
    int           first;
    bit           hit;

    initial begin
        dly.push_back('0);
        dly.push_back('0);
        m_phase   = 0;
        since_rst = 0;
        m_lvl     = '0;
        m_prev    = '0;
        for (int c = 0; c < W; c++) run[c] = 0;
        clr_stats();

        // Reset held with all inputs high: outputs stay low.
        for (int k = 0; k < 6; k++) cyc(4'hF, 1'b0);
        chk("rst_level", 32'(bif.level_out), 32'h0);
        chk("rst_rise",  32'(bif.rise_out),  32'h0);

        // Release with inputs held: three ticks (edges 4, 8, 12) to press.
        clr_stats();
        first = -1;
        for (int k = 0; k < 20; k++) begin
            cyc(4'hF, 1'b1);
            if (bif.level_out == 4'hF && first < 0) first = since_rst;
        end
        chk("rst_lat", first, 12);
        chk("rst_rise_cnt", n_rise[0] + n_rise[1] + n_rise[2] + n_rise[3], 4);
        chk("rst_rise1111_shared", n_rise[3], 1);

        // Drop everything: every channel falls once.
        clr_stats();
        for (int k = 0; k < 10; k++) cyc(4'h0, 1'b1);
        chk("all_fall_cnt", n_fall[0] + n_fall[1] + n_fall[2] + n_fall[3], 4);

        // Clean press on channel 0.
        for (int k = 0; k < 3; k++) cyc(4'h0, 1'b0);
        clr_stats();
        for (int k = 0; k < 20; k++) cyc(4'b0001, 1'b1);
        chk("press_rise0", n_rise[0], 1);
        chk("press_fall0", n_fall[0], 0);
        chk("press_level0", 32'(bif.level_out), 32'b0001);

        // Bounce on channel 1: two high samples, one low sample, then high.
        clr_stats();
        a = 4'b0011;
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            cyc(a, 1'b1);
            if (run[1] == 2) hit = 1;
        end
        chk("bounce_hi_bound", 32'(hit), 32'h1);
        a = 4'b0001;
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            cyc(a, 1'b1);
            if (run[1] == 0) hit = 1;
        end
        chk("bounce_lo_bound", 32'(hit), 32'h1);
        chk("bounce_early", n_rise[1], 0);
        a = 4'b0011;
        for (int k = 0; k < 20; k++) cyc(a, 1'b1);
        chk("bounce_rise1", n_rise[1], 1);

        // Release channel 0: it falls on the first zero sample, no debounce.
        clr_stats();
        for (int k = 0; k < 8; k++) cyc(4'b0010, 1'b1);
        chk("release_fall0", n_fall[0], 1);
        chk("release_level", 32'(bif.level_out), 32'b0010);
        for (int k = 0; k < 8; k++) cyc(4'b0000, 1'b1);

        // Channels 0 and 3 pressed together; channel 2 toggles every 2 cycles
        // with its low half always landing on the sampled phase.
        clr_stats();
        for (int k = 0; k < 24; k++) begin
            a = 4'b1001;
            a[2] = (m_phase == 2 || m_phase == 3);
            cyc(a, 1'b1);
        end
        chk("indep_shared_rise", n_rise1001, 1);
        chk("indep_rise0", n_rise[0], 1);
        chk("indep_lvl2", n_lvl2, 0);
        chk("indep_level", 32'(bif.level_out), 32'b1001);

        // Reset one sample before saturation: a full count is needed again.
        for (int k = 0; k < 3; k++) cyc(4'h0, 1'b0);
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            cyc(4'b0010, 1'b1);
            if (run[1] == 2) hit = 1;
        end
        chk("midrst_bound", 32'(hit), 32'h1);
        chk("midrst_pre_level", 32'(bif.level_out), 32'h0);
        for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b0);
        first = -1;
        for (int k = 0; k < 20; k++) begin
            cyc(4'b0010, 1'b1);
            if (bif.level_out[1] && first < 0) first = since_rst;
        end
        chk("midrst_lat", first, 12);

        // Randomized run with slow per-channel flips and occasional resets.
        a = 4'h0;
        for (int k = 0; k < 700; k++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(0, 5 + 6 * c) == 0) a[c] = ~a[c];
            end
            if ($urandom_range(0, 249) == 0) begin
                cyc(a, 1'b0);
                cyc(a, 1'b0);
            end else begin
                cyc(a, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel input conditioner for raw buttons and switches. Each of `WIDTH` asynchronous inputs passes through a 2-FF `synchronizer`, then a saturating debounce counter. One shared sample-tick generator schedules when all debounce counters update. Outputs are a clean debounced level plus one-cycle rising and falling pulses per channel, for use by the MMIO/UART-facing logic.

## Interface
- `WIDTH`, 4: number of independent input channels.
- `SAMPLE_CNT_MAX`, 25000: clk cycles per sample tick; must be ≥1 (1 ⇒ tick every cycle).
- `PULSE_CNT_MAX`, 150: consecutive high samples required to declare a channel pressed; must be ≥1.
- `clk` in 1: single clock for the whole block, including synchronizer flops.
- `rst_n` in 1: reset, asynchronous, active-low; the polarity and synchronicity are fixed.
- `async_in` in `WIDTH`: raw unsynchronized inputs, active-high.
- `level_out` out `WIDTH`: debounced level per channel.
- `rise_out` out `WIDTH`: one-cycle pulse on the 0→1 transition of `level_out[i]`.
- `fall_out` out `WIDTH`: one-cycle pulse on the 1→0 transition of `level_out[i]`.

## Operation
- Sync stage: `async_in` passes through one `synchronizer #(WIDTH)` instance, producing `sync_in` 2 cycles later. The synchronizer flops are power-up initialized to 0 and are not reset by `rst_n`.
- Tick generator: `samp_cnt` has width `$clog2(SAMPLE_CNT_MAX)`, minimum 1.
  - Counts 0 … `SAMPLE_CNT_MAX-1`, then wraps to 0.
  - `tick` = (`samp_cnt == SAMPLE_CNT_MAX-1`), combinational.
- Per-channel counter: `cnt[i]` has width `$clog2(PULSE_CNT_MAX+1)`. It updates only on `tick`:
  - `sync_in[i]==1` and `cnt[i] < PULSE_CNT_MAX`: increment.
  - `sync_in[i]==1` and `cnt[i] == PULSE_CNT_MAX`: hold (saturate, never wraps).
  - `sync_in[i]==0`: clear to 0.
  - No tick: hold.
- `level_out[i]` is a register loaded with (`cnt_next[i] == PULSE_CNT_MAX`). It therefore changes in the same cycle as `cnt[i]`.
- `lvl_d` is a register holding the previous `level_out`.
  - `rise_out` = `level_out & ~lvl_d`.
  - `fall_out` = `~level_out & lvl_d`.
- Channels are fully independent and share only `tick`.

## Timing
- Reset (`rst_n`=0, at any time, including mid-count): `samp_cnt`, every `cnt[i]`, `level_out`, `lvl_d`, `rise_out` and `fall_out` go to 0 immediately. The first `tick` comes `SAMPLE_CNT_MAX` cycles after `rst_n` rises.
- Press latency, measured from `async_in[i]` rising and held stable:
  - 2 cycles of synchronizer delay.
  - Plus wait to the next tick: 0 … `SAMPLE_CNT_MAX-1` cycles.
  - Plus `(PULSE_CNT_MAX-1)·SAMPLE_CNT_MAX` cycles.
  - Plus 1 register cycle to `level_out`.
- Release: `level_out` drops on the first tick sampling `sync_in[i]==0`, 1 register cycle later. There is no release debounce.
- `rise_out`/`fall_out` are high for exactly 1 cycle, in the same cycle `level_out` changes.
- Bounce: any tick sampling 0 before saturation restarts the count from 0.
- Simultaneous events: any number of channels may saturate or release on the same tick; all pulses assert in the same cycle.
- `PULSE_CNT_MAX=1`: `level_out` follows `sync_in` sampled at each tick.

## Structure
- Shared constants package/header holds:
  - default `SAMPLE_CNT_MAX` for 125 MHz: `CLK_FREQ/5000`.
  - default `PULSE_CNT_MAX`.
- One natural sub-module: the existing `synchronizer`, instantiated once with `WIDTH`.
- Tick generator, counter array (generate loop) and edge detect are written inline.

## Test plan
All scenarios use `WIDTH=4`, `SAMPLE_CNT_MAX=4`, `PULSE_CNT_MAX=3`.
- Reset: hold `rst_n`=0 with `async_in`=4'hF → all outputs 0. Release reset, hold input → first tick at cycle 3 after release; `level_out` = 4'hF after the 3rd tick; `rise_out`=4'hF for 1 cycle only.
- Clean press: `async_in[0]`=1 held → `level_out[0]` rises 2 + ≤3 + 8 + 1 cycles later; exactly one `rise_out[0]` pulse; no `fall_out`.
- Bounce: `async_in[1]` high for 2 ticks, low across 1 tick, then high → `level_out[1]` only after 3 further consecutive high ticks; no pulse earlier.
- Release: after press, drop `async_in[0]` → `level_out[0]` falls on the first tick sampling 0; `fall_out[0]` = 1 for 1 cycle.
- Independence and simultaneous: bit0 held, bit2 toggled every 2 cycles, bit3 held alongside bit0 → `level_out`=4'b1001 with a single shared-cycle `rise_out`=4'b1001; bit2 never asserts.
- Reset mid-operation: assert `rst_n`=0 one tick before saturation → outputs stay 0. After release, a full 3-tick count is required again.
